// File: rtl/dff_shift_pipe_async_reset.sv
// WIDTH-bit, DEPTH-stage delay line with stall, synchronous flush, per-stage valid
// tracking, parallel taps and an occupancy count; the capture edge is chosen by NEGEDGE.
`timescale 1ns/1ps
module dff_shift_pipe_async_reset #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter bit               NEGEDGE = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       clr_i,
  input  logic [WIDTH-1:0]           d_i,
  input  logic                       d_valid_i,
  output logic [WIDTH-1:0]           q_o,
  output logic                       q_valid_o,
  output logic [WIDTH*DEPTH-1:0]     taps_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  if (WIDTH < 1 || DEPTH < 1) begin : g_bad_param
    $error("dff_shift_pipe_async_reset: WIDTH and DEPTH must both be at least 1");
  end

  logic [DEPTH-1:0][WIDTH-1:0] s_q, s_d;
  logic [DEPTH-1:0]            v_q, v_d;
  logic [CntW-1:0]             cnt_q, cnt_d;

  always_comb begin
    s_d   = s_q;
    v_d   = v_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      s_d   = {DEPTH{RST_VAL}};
      v_d   = '0;
      cnt_d = '0;
    end else if (en_i) begin
      s_d[0] = d_i;
      v_d[0] = d_valid_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        s_d[i] = s_q[i-1];
        v_d[i] = v_q[i-1];
      end
      // Count tracks popcount(v): one word enters, the oldest leaves.
      cnt_d = cnt_q + CntW'(d_valid_i) - CntW'(v_q[DEPTH-1]);
    end
  end

  if (NEGEDGE) begin : g_negedge
    always_ff @(negedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s_q   <= {DEPTH{RST_VAL}};
        v_q   <= '0;
        cnt_q <= '0;
      end else begin
        s_q   <= s_d;
        v_q   <= v_d;
        cnt_q <= cnt_d;
      end
    end
  end else begin : g_posedge
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s_q   <= {DEPTH{RST_VAL}};
        v_q   <= '0;
        cnt_q <= '0;
      end else begin
        s_q   <= s_d;
        v_q   <= v_d;
        cnt_q <= cnt_d;
      end
    end
  end

  assign q_o        = s_q[DEPTH-1];
  assign q_valid_o  = v_q[DEPTH-1];
  assign taps_o     = s_q;
  assign fill_cnt_o = cnt_q;

endmodule

// File: tb/tb_dff_shift_pipe_async_reset.sv
// Directed bench: a falling-edge 8x4 pipeline plus a rising-edge single-stage instance.
`timescale 1ns/1ps
module tb_dff_shift_pipe_async_reset;

  logic        clk = 1'b0;
  logic        rst, en, clr, dv;
  logic [7:0]  d, q;
  logic        qv;
  logic [31:0] taps;
  logic [2:0]  cnt;

  logic        p_rst, p_en, p_clr, p_dv;
  logic [7:0]  p_d, p_q, p_taps;
  logic        p_qv;
  logic        p_cnt;

  int checks = 0;
  int errors = 0;

  logic [3:0] mv = '0;

  always #5 clk = ~clk;

  dff_shift_pipe_async_reset #(
    .WIDTH(8), .DEPTH(4), .NEGEDGE(1'b1), .RST_VAL(8'hA5)
  ) u_neg (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .d_i(d), .d_valid_i(dv),
    .q_o(q), .q_valid_o(qv), .taps_o(taps), .fill_cnt_o(cnt)
  );

  dff_shift_pipe_async_reset #(
    .WIDTH(8), .DEPTH(1), .NEGEDGE(1'b0), .RST_VAL(8'hA5)
  ) u_pos (
    .clk_i(clk), .rst_i(p_rst), .en_i(p_en), .clr_i(p_clr), .d_i(p_d), .d_valid_i(p_dv),
    .q_o(p_q), .q_valid_o(p_qv), .taps_o(p_taps), .fill_cnt_o(p_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic at(input int t);
    #(t - int'($time));
  endtask

  task automatic chk_neg(input string tag, input logic [31:0] e_taps, input logic [7:0] e_q,
                         input logic e_qv, input logic [2:0] e_cnt);
    check({tag, ".taps"}, taps, e_taps);
    check({tag, ".q"}, {24'h0, q}, {24'h0, e_q});
    check({tag, ".q_valid"}, {31'h0, qv}, {31'h0, e_qv});
    check({tag, ".fill_cnt"}, {29'h0, cnt}, {29'h0, e_cnt});
  endtask

  // Reference valid shadow for the falling-edge instance.
  always @(negedge clk or posedge rst) begin
    if (rst)       mv <= '0;
    else if (clr)  mv <= '0;
    else if (en)   mv <= {mv[2:0], dv};
  end

  always @(negedge clk) begin
    #1;
    check("inv.fill_eq_popcount", {29'h0, cnt}, 32'($countones(mv)));
    check("inv.q_valid", {31'h0, qv}, {31'h0, mv[3]});
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; d = 8'h00; dv = 1'b0;
    p_rst = 1'b1; p_en = 1'b0; p_clr = 1'b0; p_d = 8'h00; p_dv = 1'b0;

    at(1);   chk_neg("reset", 32'hA5A5A5A5, 8'hA5, 1'b0, 3'd0);
    at(12);  rst = 1'b0;
    at(13);  en = 1'b1; d = 8'h01; dv = 1'b1;
    at(16);  chk_neg("rise_ignored", 32'hA5A5A5A5, 8'hA5, 1'b0, 3'd0);

    at(21);  chk_neg("fill1", 32'hA5A5A501, 8'hA5, 1'b0, 3'd1);
    at(22);  d = 8'h02;
    at(31);  chk_neg("fill2", 32'hA5A50102, 8'hA5, 1'b0, 3'd2);
    at(32);  d = 8'h03;
    at(41);  chk_neg("fill3", 32'hA5010203, 8'hA5, 1'b0, 3'd3);
    at(42);  d = 8'h04;
    at(51);  chk_neg("fill4", 32'h01020304, 8'h01, 1'b1, 3'd4);

    at(52);  d = 8'h05;
    at(57);  rst = 1'b1;
    at(58);  chk_neg("midrst_now", 32'hA5A5A5A5, 8'hA5, 1'b0, 3'd0);
    at(61);  chk_neg("midrst_edge60", 32'hA5A5A5A5, 8'hA5, 1'b0, 3'd0);
    at(62);  rst = 1'b0;
    at(71);  chk_neg("post_rst_cap", 32'hA5A5A505, 8'hA5, 1'b0, 3'd1);
    at(72);  d = 8'h06;
    at(81);  chk_neg("refill2", 32'hA5A50506, 8'hA5, 1'b0, 3'd2);
    at(82);  d = 8'h07;
    at(91);  chk_neg("refill3", 32'hA5050607, 8'hA5, 1'b0, 3'd3);
    at(92);  d = 8'h08;
    at(101); chk_neg("refill4", 32'h05060708, 8'h05, 1'b1, 3'd4);

    at(102); en = 1'b0; d = 8'hFF; dv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      at(111 + 10 * k);
      chk_neg("stall", 32'h05060708, 8'h05, 1'b1, 3'd4);
    end
    at(132); en = 1'b1; dv = 1'b0;
    at(141); chk_neg("drain1", 32'h060708FF, 8'h06, 1'b1, 3'd3);

    at(142); clr = 1'b1; en = 1'b1; d = 8'h77; dv = 1'b1;
    at(151); chk_neg("flush", 32'hA5A5A5A5, 8'hA5, 1'b0, 3'd0);
    at(152); clr = 1'b0; d = 8'h11;
    at(161); chk_neg("post_flush", 32'hA5A5A511, 8'hA5, 1'b0, 3'd1);
    at(162); en = 1'b0;

    at(166); p_rst = 1'b0; p_en = 1'b1; p_d = 8'h3C; p_dv = 1'b1;
    at(171);
    check("pos.fall_ignored.q", {24'h0, p_q}, 32'h0000_00A5);
    check("pos.fall_ignored.cnt", {31'h0, p_cnt}, 32'h0);
    at(176);
    check("pos.cap.q", {24'h0, p_q}, 32'h0000_003C);
    check("pos.cap.q_valid", {31'h0, p_qv}, 32'h1);
    check("pos.cap.fill_cnt", {31'h0, p_cnt}, 32'h1);
    check("pos.cap.taps", {24'h0, p_taps}, 32'h0000_003C);
    at(177); p_d = 8'hC3; p_dv = 1'b0;
    at(181);
    check("pos.fall_hold.q", {24'h0, p_q}, 32'h0000_003C);
    check("pos.fall_hold.q_valid", {31'h0, p_qv}, 32'h1);

    at(183);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
